// File: rtl/qpsk_burst_sequencer.sv
// QPSK burst sequencer: standby exit, amplitude ramp, symbol-timed phase updates, ramp-down.
// Define DQPSK_DIFF_EN for differential phase encoding; the default build uses the absolute map.
module qpsk_burst_sequencer #(
  parameter int AMP_W     = 27,
  parameter int PHASE_W   = 27,
  parameter int PER_W     = 16,
  parameter int RAMP_STEP = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_en,
  input  logic [AMP_W-1:0]   amp_target,
  input  logic [PER_W-1:0]   sym_period,
  input  logic [1:0]         s_tdata,
  input  logic               s_tvalid,
  input  logic               s_tlast,
  output logic               s_tready,
  output logic               set_qpsk,
  output logic [PHASE_W-1:0] qpsk_phase,
  output logic [AMP_W-1:0]   amplitude,
  output logic               stdby,
  output logic               busy,
  output logic               underrun
);

  typedef enum logic [1:0] {IDLE, RAMP_UP, SYMBOL, RAMP_DOWN} state_t;

  localparam logic [AMP_W-1:0] STEP = AMP_W'(RAMP_STEP);

  state_t             state, state_nxt;
  logic [AMP_W-1:0]   amp_t, amp_t_nxt, amplitude_nxt;
  logic [AMP_W-1:0]   amp_up, amp_down;
  logic [PER_W-1:0]   cnt, cnt_nxt, cnt_load;
  logic               last_r, last_r_nxt;
  logic               set_qpsk_nxt, stdby_nxt, underrun_nxt;
  logic [PHASE_W-1:0] qpsk_phase_nxt, sym_phase;
  logic [1:0]         gray_idx;
  logic               boundary, accept;

  assign boundary = (cnt == '0);
  assign s_tready = tx_en && (((state == RAMP_UP) && (amplitude == amp_t)) ||
                              ((state == SYMBOL) && boundary && !last_r));
  assign accept   = s_tready && s_tvalid;

  // Periods below 2 are stretched to 2; the counter runs period-1 down to 0.
  assign cnt_load = (sym_period < PER_W'(2)) ? PER_W'(1) : sym_period - PER_W'(1);

  // Gray symbol 00,01,11,10 -> index 0..3, one quarter turn (2Q) apart.
  assign gray_idx = {s_tdata[1], s_tdata[1] ^ s_tdata[0]};

`ifdef DQPSK_DIFF_EN
  logic [PHASE_W-1:0] ref_phase;
  assign ref_phase = (state == SYMBOL) ? qpsk_phase : (PHASE_W'(1) << (PHASE_W - 3));
  assign sym_phase = ref_phase + (PHASE_W'({gray_idx, 1'b0}) << (PHASE_W - 3));
`else
  assign sym_phase = PHASE_W'({gray_idx, 1'b1}) << (PHASE_W - 3);
`endif

  assign amp_up   = ((amp_t - amplitude) <= STEP) ? amp_t : amplitude + STEP;
  assign amp_down = (amplitude <= STEP) ? '0 : amplitude - STEP;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_nxt      = state;
    amp_t_nxt      = amp_t;
    amplitude_nxt  = amplitude;
    cnt_nxt        = cnt;
    last_r_nxt     = last_r;
    set_qpsk_nxt   = set_qpsk;
    qpsk_phase_nxt = qpsk_phase;
    stdby_nxt      = stdby;
    underrun_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (tx_en && s_tvalid) begin
          state_nxt = RAMP_UP;
          stdby_nxt = 1'b0;
          amp_t_nxt = amp_target;
        end
      end
      RAMP_UP: begin
        if (!tx_en) begin
          state_nxt = RAMP_DOWN;
        end else if (accept) begin
          state_nxt      = SYMBOL;
          qpsk_phase_nxt = sym_phase;
          set_qpsk_nxt   = 1'b1;
          cnt_nxt        = cnt_load;
          last_r_nxt     = s_tlast;
        end else begin
          amplitude_nxt = amp_up;
        end
      end
      SYMBOL: begin
        if (!boundary) begin
          cnt_nxt = cnt - PER_W'(1);
        end else if (accept) begin
          qpsk_phase_nxt = sym_phase;
          cnt_nxt        = cnt_load;
          last_r_nxt     = s_tlast;
        end else begin
          // Starvation only when the burst was meant to continue.
          state_nxt    = RAMP_DOWN;
          underrun_nxt = tx_en && !last_r;
        end
      end
      RAMP_DOWN: begin
        if (amplitude == '0) begin
          state_nxt      = IDLE;
          set_qpsk_nxt   = 1'b0;
          qpsk_phase_nxt = '0;
          stdby_nxt      = 1'b1;
        end else begin
          amplitude_nxt = amp_down;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      amp_t      <= '0;
      amplitude  <= '0;
      cnt        <= '0;
      last_r     <= 1'b0;
      set_qpsk   <= 1'b0;
      qpsk_phase <= '0;
      stdby      <= 1'b1;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      amp_t      <= amp_t_nxt;
      amplitude  <= amplitude_nxt;
      cnt        <= cnt_nxt;
      last_r     <= last_r_nxt;
      set_qpsk   <= set_qpsk_nxt;
      qpsk_phase <= qpsk_phase_nxt;
      stdby      <= stdby_nxt;
      busy       <= (state_nxt != IDLE);
      underrun   <= underrun_nxt;
    end
  end

endmodule
